// File: rtl/ecc_10_pkg.sv
// Shared definitions for the 10-bit ECC write encoder and read-side checker.
// Holds the default widths, the codeword width, the injection mode encodings,
// the parity function and the injection mask helper.
package ecc_10_pkg;

    localparam int unsigned DataWidth   = 10;
    localparam int unsigned ParityWidth = 5;
    localparam int unsigned CwWidth     = DataWidth + ParityWidth;

    typedef enum logic [1:0] {
        InjNone   = 2'b00,
        InjSingle = 2'b01,
        InjDouble = 2'b10
    } inj_mode_e;

    typedef enum logic [0:0] {
        StIdle,
        StArmed
    } inj_state_e;

    // Parity bits for a 10-bit payload; each check bit covers six data bits.
    function automatic logic [ParityWidth-1:0] ecc_parity(input logic [DataWidth-1:0] d);
        logic [ParityWidth-1:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9];
        p[4] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
        return p;
    endfunction

    // Bit-flip mask for an injected error. Positions beyond the codeword fold
    // to bit 0; the double-flip partner wraps from bit 14 back to bit 0.
    // The unused mode 2'b11 produces no flip.
    function automatic logic [CwWidth-1:0] inj_mask(input inj_mode_e mode,
                                                    input logic [3:0] pos);
        logic [CwWidth-1:0] m;
        logic [3:0]         p0;
        logic [3:0]         p1;
        m  = '0;
        p0 = (pos > 4'd14) ? 4'd0 : pos;
        p1 = (p0 == 4'd14) ? 4'd0 : p0 + 4'd1;
        case (mode)
            InjSingle: m[p0] = 1'b1;
            InjDouble: begin
                m[p0] = 1'b1;
                m[p1] = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ecc_10_enc.sv
// Combinational parity generator.
// Ports:
//   data     - 10-bit payload
//   codeword - {parity[4:0], data[9:0]}
module ecc_10_enc
    import ecc_10_pkg::*;
(
    input  logic [DataWidth-1:0] data,
    output logic [CwWidth-1:0]   codeword
);

    assign codeword = {ecc_parity(data), data};

endmodule

// File: rtl/ecc_10_wr_enc.sv
// ECC write-side encoder: accepts payload words, appends parity, optionally
// corrupts one word for error-injection testing, and queues codewords in a
// 2-entry buffer toward storage with an auto-incrementing address.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   in_valid/in_ready/in_data   - upstream write handshake
//   out_valid/out_ready         - storage-side handshake
//   out_data/out_addr           - codeword and its storage address
//   inj_req/inj_mode/inj_pos    - error injection request
//   inj_done                    - one-cycle pulse on the corrupting acceptance
// Injection logic is built only when ECC_ERR_INJ_EN is defined; otherwise the
// inj_* inputs are ignored and inj_done is tied low.
module ecc_10_wr_enc
    import ecc_10_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DataWidth,
    parameter int unsigned PARITY_WIDTH = ParityWidth,
    parameter int unsigned ADDR_WIDTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH+PARITY_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]              out_addr,
    input  logic                               inj_req,
    input  logic [1:0]                         inj_mode,
    input  logic [3:0]                         inj_pos,
    output logic                               inj_done
);

    localparam int unsigned CwW = DATA_WIDTH + PARITY_WIDTH;

    logic           accept;
    logic           drain;
    logic [CwW-1:0] enc_cw;
    logic [CwW-1:0] err_mask;
    logic [CwW-1:0] wr_cw;

    // ---------------------------------------------------------------------
    // Parity generation
    // ---------------------------------------------------------------------
    ecc_10_enc u_enc (
        .data     (in_data),
        .codeword (enc_cw)
    );

    assign wr_cw = enc_cw ^ err_mask;

    // ---------------------------------------------------------------------
    // Error injection FSM
    // ---------------------------------------------------------------------
`ifdef ECC_ERR_INJ_EN
    inj_state_e state_q, state_d;
    inj_mode_e  mode_q;
    logic [3:0] pos_q;
    logic       arm;

    assign arm = (state_q == StIdle) && inj_req && (inj_mode != InjNone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= InjNone;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            if (arm) begin
                mode_q <= inj_mode_e'(inj_mode);
                pos_q  <= inj_pos;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (arm)    state_d = StArmed;
            StArmed: if (accept) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        inj_done = 1'b0;
        err_mask = '0;
        if (state_q == StArmed && accept) begin
            inj_done = 1'b1;
            err_mask = inj_mask(mode_q, pos_q);
        end
    end
`else
    logic unused_inj;
    assign unused_inj = ^{inj_req, inj_mode, inj_pos};
    assign inj_done   = 1'b0;
    assign err_mask   = '0;
`endif

    // ---------------------------------------------------------------------
    // Two-entry output buffer
    // ---------------------------------------------------------------------
    logic [CwW-1:0]        mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  in_ready_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign accept    = in_valid && in_ready_q;
    assign drain     = out_valid && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        addr_d   = addr_q;
        if (accept) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (drain) begin
            rd_ptr_d = ~rd_ptr_q;
            addr_d   = addr_q + ADDR_WIDTH'(1);
        end
        case ({accept, drain})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // in_ready is registered from the post-edge occupancy so it never has a
    // combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            in_ready_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= wr_cw;
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            in_ready_q <= (occ_d < 2'd2);
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_ecc_10_wr_enc.sv
module tb_ecc_10_wr_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_data;
    logic [3:0]  out_addr;
    logic        inj_req;
    logic [1:0]  inj_mode;
    logic [3:0]  inj_pos;
    logic        inj_done;

    ecc_10_wr_enc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .inj_req   (inj_req),
        .inj_mode  (inj_mode),
        .inj_pos   (inj_pos),
        .inj_done  (inj_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] cw;
        logic [3:0]  addr;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_addr;
    logic [3:0] last_addr;
    int         total;
    int         bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference parity straight from the check-bit equations.
    function automatic logic [14:0] ref_cw(input logic [9:0] d);
        logic [4:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9];
        p[4] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
        return {p, d};
    endfunction

    // Monitor: values are stable from negedge to the following posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h expected none", out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e.cw));
                chk("out_addr", 32'(out_addr), 32'(e.addr));
                last_addr = out_addr;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic write(input logic [9:0] d, input logic [14:0] cw, input logic exp_inj);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_accept", 32'(in_ready), 32'd1);
        if (in_ready) begin
            sb.push_back('{cw: cw, addr: exp_addr});
            exp_addr = exp_addr + 4'd1;
            chk("inj_done", 32'(inj_done), 32'(exp_inj));
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic arm(input logic [1:0] m, input logic [3:0] p);
        inj_req  = 1'b1;
        inj_mode = m;
        inj_pos  = p;
        step();
        inj_req  = 1'b0;
        inj_mode = 2'b00;
        inj_pos  = 4'd0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        exp_addr  = 4'd0;
        last_addr = 4'hF;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inj_req   = 1'b0;
        inj_mode  = 2'b00;
        inj_pos   = 4'd0;

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_addr", 32'(out_addr), 32'd0);
        chk("rst_inj_done", 32'(inj_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Basic encoding, one-cycle latency
        write(10'h001, 15'h4C01, 1'b0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        chk("first_addr", 32'(out_addr), 32'd0);
        write(10'h3FF, 15'h03FF, 1'b0);
        write(10'h000, 15'h0000, 1'b0);
        write(10'h2AA, 15'h6AAA, 1'b0);
        write(10'h200, 15'h3A00, 1'b0);
        wait_drain();

        // Back-pressure: two accepted, third held off, order kept
        out_ready = 1'b0;
        write(10'h200, 15'h3A00, 1'b0);
        write(10'h001, 15'h4C01, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_data", 32'(out_data), 32'h3A00);
        repeat (2) @(negedge clk);
        chk("stall_out_data", 32'(out_data), 32'h3A00);
        chk("stall_out_addr", 32'(out_addr), 32'(exp_addr - 4'd2));
        step();
        fork
            write(10'h3FF, 15'h03FF, 1'b0);
            begin
                repeat (3) step();
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Error injection
`ifdef ECC_ERR_INJ_EN
        arm(2'b01, 4'd0);
        write(10'h001, 15'h4C00, 1'b1);
        write(10'h001, 15'h4C01, 1'b0);
        arm(2'b10, 4'd0);
        write(10'h001, 15'h4C02, 1'b1);
        arm(2'b01, 4'd15);
        write(10'h000, 15'h0001, 1'b1);
        arm(2'b10, 4'd14);
        write(10'h000, 15'h4001, 1'b1);
        arm(2'b01, 4'd3);
        arm(2'b01, 4'd5);
        write(10'h3FF, 15'h03F7, 1'b1);
        write(10'h3FF, 15'h03FF, 1'b0);
`else
        arm(2'b01, 4'd0);
        write(10'h001, 15'h4C01, 1'b0);
        arm(2'b10, 4'd0);
        write(10'h001, 15'h4C01, 1'b0);
`endif
        wait_drain();

        // Reset with two words buffered
        out_ready = 1'b0;
        write(10'h2AA, 15'h6AAA, 1'b0);
        write(10'h200, 15'h3A00, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_out_addr", 32'(out_addr), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        sb.delete();
        exp_addr = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_out_addr", 32'(out_addr), 32'd0);

        // Address wrap: 17th transfer lands at address 0
        for (int i = 0; i < 17; i++) begin
            write(10'(i * 37 + 5), ref_cw(10'(i * 37 + 5)), 1'b0);
        end
        wait_drain();
        chk("wrap_17th_addr", 32'(last_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_10_wr_enc.md
ECC_10_WR_ENC -- requirements
Module: ecc_10_wr_enc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, payload width.
REQ-002 SHALL have parameter PARITY_WIDTH, default 5, check-bit width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, FIFO storage address width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_WIDTH: upstream write handshake.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: storage-side handshake.
REQ-008 SHALL have ports out_data output DATA_WIDTH+PARITY_WIDTH (codeword) and out_addr output ADDR_WIDTH (storage address).
REQ-009 SHALL have ports inj_req input 1, inj_mode input 2, inj_pos input 4, inj_done output 1: error injection control.

Function
REQ-010 SHALL compute parity by XOR: p0=d0^d1^d3^d4^d6^d8; p1=d0^d2^d3^d5^d6^d9; p2=d1^d2^d3^d7^d8^d9; p3=d4^d5^d6^d7^d8^d9; p4=d0^d1^d2^d4^d5^d7.
REQ-011 SHALL pack codeword as {parity[4:0], data[9:0]}, parity in bits 14:10.
REQ-012 SHALL transfer a word on a port only in a cycle where valid and ready are both 1.
REQ-013 SHALL hold a 2-entry output buffer (occupancy 0/1/2); in_ready SHALL be a register equal to (occupancy<2) after the edge, never combinationally derived from out_ready.
REQ-014 SHALL present an accepted word on out_valid the cycle after acceptance when buffer was empty (latency 1 cycle).
REQ-015 SHALL keep out_data/out_addr stable while out_valid=1 and out_ready=0.
REQ-016 SHALL, on simultaneous accept and drain, keep occupancy unchanged and preserve order.
REQ-017 SHALL increment out_addr after each output transfer, wrapping 2^ADDR_WIDTH-1 -> 0.
REQ-018 SHALL implement injection FSM IDLE->ARMED on inj_req=1 with inj_mode!=0 (capture mode/pos); ARMED->IDLE on next input acceptance, corrupting that word only.
REQ-019 SHALL, for inj_mode=2'b01, flip codeword bit inj_pos; for 2'b10, flip bits inj_pos and (inj_pos+1) mod 15; inj_pos>14 SHALL be treated as 0.
REQ-020 SHALL ignore inj_req while ARMED and pulse inj_done for one cycle on the corrupting acceptance.

Reset
REQ-021 SHALL on rst_n=0 immediately clear occupancy, FSM to IDLE, out_addr=0, out_valid=0, in_ready=0, out_data=0, inj_done=0.
REQ-022 SHALL drive in_ready=1 the first edge after rst_n deasserts; reset mid-transfer SHALL discard buffered words.

Configuration
REQ-023 SHALL compile injection logic only when ECC_ERR_INJ_EN is defined; undefined: inj_* inputs ignored, inj_done constant 0, codewords never corrupted, ports retained.

Structure
REQ-024 SHALL place DATA_WIDTH/PARITY_WIDTH defaults, codeword width, inj_mode encodings and parity function in shared package ecc_10_pkg, reused by the read-side checker.
REQ-025 SHALL instantiate one sub-module ecc_10_enc (combinational parity generator); buffer and FSM live in the top.

Verification
REQ-026 in_data=10'h001, out_ready=1 -> out_data=15'h4C01, out_addr=0, one cycle later.
REQ-027 in_data=10'h3FF -> out_data=15'h03FF; in_data=10'h000 -> 15'h0000.
REQ-028 out_ready=0, 3 writes offered -> 2 accepted, in_ready=0, order preserved on release.
REQ-029 17 transfers with ADDR_WIDTH=4 -> 17th out_addr=0.
REQ-030 ECC_ERR_INJ_EN, mode 01 pos 0, data 10'h001 -> 15'h4C00, inj_done pulse; next word clean. Mode 10 pos 0 -> 15'h4C02.
REQ-031 rst_n low with occupancy 2 -> out_valid=0 immediately, out_addr=0 after release.
